// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI link and backing-memory bus bundle for spi_flash_responder
//
// Purpose: groups the boot SPI pins and the synchronous byte-wide memory
// read port so the responder and its environment connect through one bundle.
// Signal names keep the responder's point of view (_i = into the responder).
//
// Signals:
//   spi_sck_i    SPI clock from the boot master (asynchronous to clk_i)
//   spi_mosi_i   master-out data, MSB first
//   spi_miso_o   responder-out data, MSB first
//   flash_csb_i  active-low chip select
//   mem_rd_o     one-cycle read strobe to the backing memory
//   mem_addr_o   read address, valid while mem_rd_o is high
//   mem_data_i   read data, valid one clk_i cycle after mem_rd_o
//
// Modports:
//   slave   the responder
//   master  the environment (SPI master plus backing memory)
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck_i;
  logic              spi_mosi_i;
  logic              spi_miso_o;
  logic              flash_csb_i;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;

  modport slave (
    input  spi_sck_i,
    input  spi_mosi_i,
    input  flash_csb_i,
    input  mem_data_i,
    output spi_miso_o,
    output mem_rd_o,
    output mem_addr_o
  );

  modport master (
    output spi_sck_i,
    output spi_mosi_i,
    output flash_csb_i,
    output mem_data_i,
    input  spi_miso_o,
    input  mem_rd_o,
    input  mem_addr_o
  );
endinterface

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial NOR flash read-port emulator
//
// Purpose: far end of the boot SPI link. Decodes standard read commands
// (opcode, 24-bit address) and streams bytes from a synchronous byte-wide
// memory on MISO until chip select rises. All SPI pins are oversampled in
// the clk_i domain, so clk_i must run at least 16x the SCK rate.
//
// Optional feature macro: SPI_FLASH_FAST_READ_EN
//   defined   - opcode 8'h0B is also accepted and is followed by 8 dummy clocks
//   undefined - 8'h0B is an unsupported opcode
//
// Ports:
//   clk_i      system clock
//   reset_i    asynchronous active-high reset
//   bus        spi_flash_responder_if.slave (SPI pins + memory read port)
//   busy_o     high whenever the FSM is not idle
//   cmd_err_o  one-cycle pulse after an unsupported opcode
module spi_flash_responder #(
  parameter int         ADDR_W   = 24,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  spi_flash_responder_if.slave   bus,
  output logic                   busy_o,
  output logic                   cmd_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Synchronisers. SCK and MOSI get a third stage so the registered edge
  // strobes and the sampled MOSI bit line up. CSB is used straight from the
  // second stage, which makes it reach the FSM a cycle ahead of any SCK
  // strobe from the same instant, so CSB always wins a tie.
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic mosi_s1_q, mosi_s2_q, mosi_s3_q;
  logic csb_s1_q, csb_s2_q, csb_prev_q;
  logic rise_q, fall_q;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [23:0]       shin_q, shin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shout_q, shout_d;
  logic [7:0]        pref_q, pref_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              miso_q, miso_d;
  logic              err_q, err_d;
  logic              rd_pend_q;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        opcode;
  logic [23:0]       addr_full;
  logic [ADDR_W-1:0] addr_cap;
  logic [ADDR_W-1:0] addr_inc;
  logic              opcode_ok;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_s3_q   <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      mosi_s3_q  <= 1'b0;
      csb_s1_q   <= 1'b1;
      csb_s2_q   <= 1'b1;
      csb_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sck_s1_q   <= bus.spi_sck_i;
      sck_s2_q   <= sck_s1_q;
      sck_s3_q   <= sck_s2_q;
      mosi_s1_q  <= bus.spi_mosi_i;
      mosi_s2_q  <= mosi_s1_q;
      mosi_s3_q  <= mosi_s2_q;
      csb_s1_q   <= bus.flash_csb_i;
      csb_s2_q   <= csb_s1_q;
      csb_prev_q <= csb_s2_q;
      rise_q     <= sck_s2_q & ~sck_s3_q;
      fall_q     <= ~sck_s2_q & sck_s3_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shin_q    <= '0;
      addr_q    <= '0;
      shout_q   <= '0;
      pref_q    <= '0;
      fcnt_q    <= '0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shin_q    <= shin_d;
      addr_q    <= addr_d;
      shout_q   <= shout_d;
      pref_q    <= pref_d;
      fcnt_q    <= fcnt_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
      rd_pend_q <= mem_rd;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q    <= fast_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shin_d    = shin_q;
    addr_d    = addr_q;
    shout_d   = shout_q;
    pref_d    = pref_q;
    fcnt_d    = fcnt_q;
    miso_d    = miso_q;
    err_d     = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = addr_q;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d    = fast_q;
`endif
    opcode    = {shin_q[6:0], mosi_s3_q};
    addr_full = {shin_q[22:0], mosi_s3_q};
    addr_cap  = ADDR_W'(addr_full);
    addr_inc  = addr_q + ADDR_W'(1);
    opcode_ok = (opcode == READ_CMD);
`ifdef SPI_FLASH_FAST_READ_EN
    opcode_ok = opcode_ok || (opcode == 8'h0B);
`endif

    // Memory data returns one cycle after the strobe. Data belonging to a
    // transfer that has been aborted never lands in the prefetch register.
    if (rd_pend_q && state_q == ST_DATA && !csb_s2_q) begin
      pref_d = bus.mem_data_i;
    end

    if (state_q != ST_IDLE && csb_s2_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          miso_d = 1'b0;
          if (!csb_s2_q && csb_prev_q) begin
            state_d = ST_CMD;
          end
        end

        ST_CMD: begin
          if (rise_q) begin
            shin_d = addr_full;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (opcode_ok) begin
                state_d = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                fast_d  = (opcode == 8'h0B) && (READ_CMD != 8'h0B);
`endif
              end else begin
                err_d   = 1'b1;
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR: begin
          if (rise_q) begin
            shin_d = addr_full;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d  = '0;
              addr_d = addr_cap;
              fcnt_d = '0;
`ifdef SPI_FLASH_FAST_READ_EN
              if (fast_q) begin
                state_d = ST_DUMMY;
              end else begin
                mem_rd   = 1'b1;
                mem_addr = addr_cap;
                state_d  = ST_DATA;
              end
`else
              mem_rd   = 1'b1;
              mem_addr = addr_cap;
              state_d  = ST_DATA;
`endif
            end
          end
        end

`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          miso_d = 1'b0;
          if (rise_q) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d    = '0;
              fcnt_d   = '0;
              mem_rd   = 1'b1;
              mem_addr = addr_q;
              state_d  = ST_DATA;
            end
          end
        end
`endif

        ST_DATA: begin
          // Falls drive bits; the first fall of each byte pulls the next
          // byte out of the prefetch register.
          if (fall_q) begin
            fcnt_d = fcnt_q + 3'd1;
            if (fcnt_q == 3'd0) begin
              miso_d  = pref_q[7];
              shout_d = {pref_q[6:0], 1'b0};
            end else begin
              miso_d  = shout_q[7];
              shout_d = {shout_q[6:0], 1'b0};
            end
          end
          // The rise that completes a byte fetches the following one.
          if (rise_q) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q[2:0] == 3'd7) begin
              cnt_d    = '0;
              addr_d   = addr_inc;
              mem_rd   = 1'b1;
              mem_addr = addr_inc;
            end
          end
        end

        ST_IGNORE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.spi_miso_o = miso_q;
  assign bus.mem_rd_o   = mem_rd;
  assign bus.mem_addr_o = mem_addr;
  assign busy_o         = (state_q != ST_IDLE);
  assign cmd_err_o      = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int HALF = 100;

  logic clk;
  logic rst;
  logic busy;
  logic cmd_err;

  int checks   = 0;
  int failures = 0;

  int rd_cnt  = 0;
  int err_cnt = 0;
  int b2b_cnt = 0;
  logic rd_prev = 1'b0;
  logic [23:0] addr_log [$];

  logic [7:0] rxb [0:7];
  logic [7:0] dummy;
  int rd_base;
  int err_base;
  int log_base;

  spi_flash_responder_if #(.ADDR_W(24)) bus ();

  spi_flash_responder #(.ADDR_W(24), .READ_CMD(8'h03)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .bus       (bus.slave),
    .busy_o    (busy),
    .cmd_err_o (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: byte = addr[7:0] ^ 8'hA5, one cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_o) bus.mem_data_i <= bus.mem_addr_o[7:0] ^ 8'hA5;
  end

  always @(negedge clk) begin
    if (bus.mem_rd_o) begin
      rd_cnt = rd_cnt + 1;
      addr_log.push_back(bus.mem_addr_o);
      if (rd_prev) b2b_cnt = b2b_cnt + 1;
    end
    rd_prev = bus.mem_rd_o;
    if (cmd_err) err_cnt = err_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation time limit reached, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi_i = tx[i];
      #HALF;
      bus.spi_sck_i = 1'b1;
      rx[i] = bus.spi_miso_o;
      #HALF;
      bus.spi_sck_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.flash_csb_i = 1'b0;
    #HALF;
  endtask

  task automatic cs_stop();
    #HALF;
    bus.flash_csb_i = 1'b1;
    #(HALF);
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
    logic [7:0] r;
    cs_start();
    spi_byte(op, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, r);
      rxb[k] = r;
    end
    cs_stop();
  endtask

  initial begin
    rst = 1'b1;
    bus.spi_sck_i   = 1'b0;
    bus.spi_mosi_i  = 1'b0;
    bus.flash_csb_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_miso", {31'd0, bus.spi_miso_o}, 32'd0);
    chk("reset_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("reset_addr", {8'd0, bus.mem_addr_o}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, cmd_err}, 32'd0);

    // Basic read at 0x10
    rd_base = rd_cnt; log_base = addr_log.size();
    do_read(8'h03, 24'h000010, 4);
    chk("basic_b0", {24'd0, rxb[0]}, 32'hB5);
    chk("basic_b1", {24'd0, rxb[1]}, 32'hB4);
    chk("basic_b2", {24'd0, rxb[2]}, 32'hB7);
    chk("basic_b3", {24'd0, rxb[3]}, 32'hB6);
    chk("basic_rd_cnt", rd_cnt - rd_base, 32'd5);
    chk("basic_a0", {8'd0, addr_log[log_base+0]}, 32'h10);
    chk("basic_a1", {8'd0, addr_log[log_base+1]}, 32'h11);
    chk("basic_a2", {8'd0, addr_log[log_base+2]}, 32'h12);
    chk("basic_a3", {8'd0, addr_log[log_base+3]}, 32'h13);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    // Address wrap
    log_base = addr_log.size();
    do_read(8'h03, 24'hFFFFFE, 4);
    chk("wrap_a0", {8'd0, addr_log[log_base+0]}, 32'hFFFFFE);
    chk("wrap_a1", {8'd0, addr_log[log_base+1]}, 32'hFFFFFF);
    chk("wrap_a2", {8'd0, addr_log[log_base+2]}, 32'h000000);
    chk("wrap_a3", {8'd0, addr_log[log_base+3]}, 32'h000001);
    chk("wrap_b0", {24'd0, rxb[0]}, 32'h5B);
    chk("wrap_b2", {24'd0, rxb[2]}, 32'hA5);

    // Unsupported opcode
    rd_base = rd_cnt; err_base = err_cnt;
    cs_start();
    spi_byte(8'h9F, dummy);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'hFF, dummy);
      rxb[k] = dummy;
    end
    chk("bad_busy", {31'd0, busy}, 32'd1);
    cs_stop();
    chk("bad_err_pulses", err_cnt - err_base, 32'd1);
    chk("bad_rd_cnt", rd_cnt - rd_base, 32'd0);
    chk("bad_miso_b0", {24'd0, rxb[0]}, 32'h00);
    chk("bad_miso_b1", {24'd0, rxb[1]}, 32'h00);
    chk("bad_miso_b2", {24'd0, rxb[2]}, 32'h00);
    chk("bad_miso_b3", {24'd0, rxb[3]}, 32'h00);
    do_read(8'h03, 24'h000020, 1);
    chk("after_bad_b0", {24'd0, rxb[0]}, 32'h85);

    // Abort after 12 address bits
    rd_base = rd_cnt;
    cs_start();
    spi_byte(8'h03, dummy);
    spi_byte(8'h00, dummy);
    spi_bits(8'h00, 4, dummy);
    bus.flash_csb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_addr_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr_rd", rd_cnt - rd_base, 32'd0);
    repeat (10) @(negedge clk);

    // Abort mid-byte in DATA
    rd_base = rd_cnt;
    cs_start();
    spi_byte(8'h03, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h40, dummy);
    spi_byte(8'h00, dummy);
    chk("abort_data_b0", {24'd0, dummy}, 32'hE5);
    bus.spi_mosi_i = 1'b0;
    #HALF; bus.spi_sck_i = 1'b1;
    #HALF; bus.spi_sck_i = 1'b0;
    #HALF; bus.spi_sck_i = 1'b1;
    chk("abort_data_miso_pre", {31'd0, bus.spi_miso_o}, 32'd1);
    #HALF;
    bus.spi_sck_i   = 1'b0;
    bus.flash_csb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_data_miso", {31'd0, bus.spi_miso_o}, 32'd0);
    chk("abort_data_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_data_rd", rd_cnt - rd_base, 32'd2);

    // Asynchronous reset mid-DATA
    cs_start();
    spi_byte(8'h03, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h5A, dummy);
    spi_byte(8'h00, dummy);
    chk("rst_b0", {24'd0, dummy}, 32'hFF);
    #50;
    chk("rst_pre_miso", {31'd0, bus.spi_miso_o}, 32'd1);
    chk("rst_pre_addr", {8'd0, bus.mem_addr_o}, 32'h5B);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_miso", {31'd0, bus.spi_miso_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {8'd0, bus.mem_addr_o}, 32'd0);
    chk("rst_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    bus.flash_csb_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_read(8'h03, 24'h000010, 1);
    chk("after_rst_b0", {24'd0, rxb[0]}, 32'hB5);

    // Fast read opcode
`ifdef SPI_FLASH_FAST_READ_EN
    cs_start();
    spi_byte(8'h0B, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    cs_stop();
    chk("fast_b0", {24'd0, dummy}, 32'hA5);
`else
    rd_base = rd_cnt; err_base = err_cnt;
    cs_start();
    spi_byte(8'h0B, dummy);
    spi_byte(8'h00, dummy);
    cs_stop();
    chk("fast_err_pulses", err_cnt - err_base, 32'd1);
    chk("fast_rd_cnt", rd_cnt - rd_base, 32'd0);
`endif

    chk("rd_back_to_back", b2b_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
